// File: rtl/aes_mc_multi_column.sv
// Sequential masked-AES MixColumns engine: applies forward or inverse MixColumns
// share-wise to D shares, NCOLS columns per cycle, with valid/ready on both sides.
module aes_mc_multi_column #(
  parameter int NCOLS = 1,
  parameter int D     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_inverse,
  input  logic [128*D-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [128*D-1:0] out_data,
  output logic           busy
);

  localparam int N  = 4 / NCOLS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = 32 * NCOLS;

  if (!((NCOLS == 1) || (NCOLS == 2) || (NCOLS == 4)) || (D < 1)) begin : g_bad_cfg
    $error("aes_mc_multi_column: NCOLS must be 1, 2 or 4 and D must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t              fsm;
  logic [CW-1:0]     cnt;
  logic              mode;
  logic [128*D-1:0]  state;
  logic              accept;
  logic [D-1:0][GW-1:0] grp_in;
  logic [D-1:0][GW-1:0] grp_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Both directions share one xtime chain (x2, x4, x8) per byte; the mode picks the result.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [3:0][7:0] a, x2, x4, x8, m3, m9, mb, md, me, b;
    a = col;
    for (int r = 0; r < 4; r++) begin
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m3[r] = x2[r] ^ a[r];
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    for (int r = 0; r < 4; r++) begin
      b[r] = inv ? (me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4])
                 : (x2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4]  ^ a[(r+3)%4]);
    end
    return b;
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_data  = state;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    grp_in  = '0;
    grp_out = '0;
    for (int s = 0; s < D; s++) begin
      for (int g = 0; g < N; g++) begin
        if (cnt == CW'(g)) grp_in[s] = state[128*s + GW*g +: GW];
      end
      for (int k = 0; k < NCOLS; k++) begin
        grp_out[s][32*k +: 32] = mix_col(grp_in[s][32*k +: 32], mode);
      end
    end
  end

  // NOTE: state is non-blocking only; the data register is reset as well so an
  // aborted transaction leaves no trace behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      state <= '0;
    end else if (accept) begin
      state <= in_data;
      mode  <= in_inverse;
      cnt   <= '0;
      fsm   <= RUN;
    end else begin
      case (fsm)
        RUN: begin
          for (int s = 0; s < D; s++) begin
            for (int g = 0; g < N; g++) begin
              if (cnt == CW'(g)) state[128*s + GW*g +: GW] <= grp_out[s];
            end
          end
          if (cnt == CW'(N - 1)) fsm <= DONE;
          else                   cnt <= cnt + 1'b1;
        end
        DONE:    if (out_ready) fsm <= IDLE;
        IDLE:    fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mc_multi_column.sv
// Directed bench for aes_mc_multi_column: FIPS-197 vectors, inverse round trips for
// NCOLS 1/2/4, masked shares, backpressure, back-to-back, abort by reset, mode latching.
module tb_aes_mc_multi_column;

  localparam logic [127:0] VA  = {32'h5c220af2, 32'h01010101, 32'hc6c6c6c6, 32'h455313db};
  localparam logic [127:0] MCA = {32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6, 32'hbca14d8e};
  localparam logic [127:0] VB  = {32'he598271e, 32'hf11141b8, 32'hae52b4e0, 32'h305dbfd4};
  localparam logic [127:0] MCB = {32'h4c260628, 32'h7ad3f848, 32'h9a19cbe0, 32'he5816604};
  localparam logic [127:0] R2  = {4{32'h5a5a5a5a}};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // D=1 instances with NCOLS = 1, 2, 4 at index 0, 1, 2
  logic         in_valid_a   [3];
  logic         in_ready_a   [3];
  logic         in_inverse_a [3];
  logic [127:0] in_data_a    [3];
  logic         out_valid_a  [3];
  logic         out_ready_a  [3];
  logic [127:0] out_data_a   [3];
  logic         busy_a       [3];

  // D=3, NCOLS=1 instance
  logic         s_in_valid, s_in_ready, s_in_inverse, s_out_valid, s_out_ready, s_busy;
  logic [383:0] s_in_data, s_out_data;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    aes_mc_multi_column #(.NCOLS(1 << i), .D(1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid_a[i]),
      .in_ready   (in_ready_a[i]),
      .in_inverse (in_inverse_a[i]),
      .in_data    (in_data_a[i]),
      .out_valid  (out_valid_a[i]),
      .out_ready  (out_ready_a[i]),
      .out_data   (out_data_a[i]),
      .busy       (busy_a[i])
    );
  end

  aes_mc_multi_column #(.NCOLS(1), .D(3)) u_shares (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_inverse (s_in_inverse),
    .in_data    (s_in_data),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_data   (s_out_data),
    .busy       (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one transaction to instance idx while it is idle; returns the result and the
  // number of rising edges from the accepting edge to out_valid (20 means it never came).
  task automatic do_txn(input int idx, input logic [127:0] data, input logic inv,
                        output logic [127:0] res, output int lat);
    @(negedge clk);
    in_valid_a[idx]   = 1'b1;
    in_data_a[idx]    = data;
    in_inverse_a[idx] = inv;
    out_ready_a[idx]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[idx] = 1'b0;
    lat = 0;
    while (!out_valid_a[idx] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_data_a[idx];
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid_a[i] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid_a[i]); end
      total++;
      if (busy_a[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_a[i]); end
      total++;
      if (in_ready_a[i] !== 1'b1) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready_a[i]); end
    end
    total++;
    if ({s_out_valid, s_busy, s_in_ready} !== 3'b001) begin
      bad++; $display("FAIL reset_shares: valid/busy/ready got %b want 001", {s_out_valid, s_busy, s_in_ready});
    end
  endtask

  task automatic test_fips_forward();
    logic [127:0] res;
    int lat;
    do_txn(0, VA, 1'b0, res, lat);
    total++;
    if (res !== MCA) begin bad++; $display("FAIL fips_fwd_data: got %h want %h", res, MCA); end
    total++;
    if (res[95:32] !== VA[95:32]) begin bad++; $display("FAIL fips_fwd_cols12: got %h want %h", res[95:32], VA[95:32]); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL fips_fwd_latency: got %0d want 4", lat); end
    do_txn(0, VB, 1'b0, res, lat);
    total++;
    if (res !== MCB) begin bad++; $display("FAIL fips_fwd_vecb: got %h want %h", res, MCB); end
  endtask

  task automatic test_inverse_roundtrip();
    logic [127:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_txn(i, MCA, 1'b1, res, lat);
      total++;
      if (res !== VA) begin bad++; $display("FAIL inv_data[ncols=%0d]: got %h want %h", 1 << i, res, VA); end
      total++;
      if (lat !== (4 >> i)) begin bad++; $display("FAIL inv_latency[ncols=%0d]: got %0d want %0d", 1 << i, lat, 4 >> i); end
      do_txn(i, VB, 1'b0, res, lat);
      total++;
      if (res !== MCB) begin bad++; $display("FAIL fwd_vecb[ncols=%0d]: got %h want %h", 1 << i, res, MCB); end
      do_txn(i, MCB, 1'b1, res, lat);
      total++;
      if (res !== VB) begin bad++; $display("FAIL inv_vecb[ncols=%0d]: got %h want %h", 1 << i, res, VB); end
    end
  endtask

  task automatic test_shares();
    logic [127:0] exp0;
    logic [127:0] sum;
    int lat;
    exp0 = MCA ^ MCB ^ R2;
    @(negedge clk);
    s_in_valid   = 1'b1;
    s_in_inverse = 1'b0;
    s_in_data    = {R2, VB, VA ^ VB ^ R2};
    s_out_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL shares_latency: got %0d want 4", lat); end
    total++;
    if (s_out_data[127:0] !== exp0) begin bad++; $display("FAIL shares_s0: got %h want %h", s_out_data[127:0], exp0); end
    total++;
    if (s_out_data[255:128] !== MCB) begin bad++; $display("FAIL shares_s1: got %h want %h", s_out_data[255:128], MCB); end
    total++;
    if (s_out_data[383:256] !== R2) begin bad++; $display("FAIL shares_s2: got %h want %h", s_out_data[383:256], R2); end
    sum = s_out_data[127:0] ^ s_out_data[255:128] ^ s_out_data[383:256];
    total++;
    if (sum !== MCA) begin bad++; $display("FAIL shares_xor: got %h want %h", sum, MCA); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    in_valid_a[0]   = 1'b1;
    in_data_a[0]    = VA;
    in_inverse_a[0] = 1'b0;
    out_ready_a[0]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    lat = 0;
    while (!out_valid_a[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL stall_latency: got %0d want 4", lat); end
    // Offer a junk transaction while stalled; it must be ignored.
    in_valid_a[0]   = 1'b1;
    in_data_a[0]    = ~VA;
    in_inverse_a[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (out_valid_a[0] !== 1'b1 || out_data_a[0] !== MCA || in_ready_a[0] !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d]: valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                 i, out_valid_a[0], in_ready_a[0], out_data_a[0], MCA);
      end
      @(negedge clk);
    end
    in_data_a[0]    = VB;
    in_inverse_a[0] = 1'b0;
    out_ready_a[0]  = 1'b1;
    #1;
    total++;
    if (in_ready_a[0] !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready_a[0]); end
    @(posedge clk);
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    total++;
    if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
      bad++; $display("FAIL b2b_accepted: valid=%b busy=%b want valid=0 busy=1", out_valid_a[0], busy_a[0]);
    end
    lat = 0;
    while (!out_valid_a[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    total++;
    if (out_data_a[0] !== MCB) begin bad++; $display("FAIL b2b_data: got %h want %h", out_data_a[0], MCB); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] res;
    logic seen;
    int lat;
    @(negedge clk);
    in_valid_a[0]   = 1'b1;
    in_data_a[0]    = VA;
    in_inverse_a[0] = 1'b0;
    out_ready_a[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
      bad++; $display("FAIL abort_async: valid=%b busy=%b want 0 0", out_valid_a[0], busy_a[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready_a[0] !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready_a[0]); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | out_valid_a[0];
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_result: out_valid seen=%b want 0", seen); end
    do_txn(0, VB, 1'b0, res, lat);
    total++;
    if (res !== MCB || lat !== 4) begin
      bad++; $display("FAIL abort_fresh: got %h lat %0d want %h lat 4", res, lat, MCB);
    end
  endtask

  task automatic test_mode_latch();
    logic [127:0] din, exp;
    logic inv;
    int lat, exp_lat;
    for (int j = 0; j < 2; j++) begin
      din     = (j == 0) ? MCA : VB;
      inv     = (j == 0) ? 1'b1 : 1'b0;
      exp     = (j == 0) ? VA : MCB;
      exp_lat = (j == 0) ? 4 : 2;
      @(negedge clk);
      in_valid_a[j]   = 1'b1;
      in_data_a[j]    = din;
      in_inverse_a[j] = inv;
      out_ready_a[j]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_a[j] = 1'b0;
      lat = 0;
      while (!out_valid_a[j] && lat < 20) begin
        in_inverse_a[j] = ~in_inverse_a[j];
        in_data_a[j]    = ~in_data_a[j];
        @(negedge clk);
        lat++;
      end
      total++;
      if (out_data_a[j] !== exp || lat !== exp_lat) begin
        bad++;
        $display("FAIL mode_latch[ncols=%0d]: got %h lat %0d want %h lat %0d",
                 1 << j, out_data_a[j], lat, exp, exp_lat);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]   = 1'b0;
      in_inverse_a[i] = 1'b0;
      in_data_a[i]    = '0;
      out_ready_a[i]  = 1'b1;
    end
    s_in_valid   = 1'b0;
    s_in_inverse = 1'b0;
    s_in_data    = '0;
    s_out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_fips_forward();
    test_inverse_roundtrip();
    test_shares();
    test_back_to_back();
    test_reset_mid_run();
    test_mode_latch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_mc_multi_column.md
# aes_mc_multi_column

Sequential, parametrised MixColumns engine for the masked AES datapath. Accepts a full 128-bit state per share and applies either forward or inverse MixColumns, selected per transaction. It processes NCOLS columns per cycle, so area can be traded against latency. The transform is linear, so it is applied share-wise to D shares with no randomness. It sits between ShiftRows and AddRoundKey and is flow-controlled by valid/ready on both sides.

## Interface
- NCOLS, 1, columns transformed per cycle; legal values 1, 2, 4; any other value is an elaboration error
- D, 2, number of shares; D >= 1
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input transaction offered
- in_ready  output  1  block can accept; combinational from state and out_ready
- in_inverse  input  1  0 = forward MixColumns, 1 = inverse; sampled only at accept
- in_data  input  128*D  share s at [128*s +: 128]; column c at [32*c +: 32]; row r of column c at [32*c+8*r +: 8]
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_data  output  128*D  transformed state, same packing as in_data; meaningful only while out_valid=1
- busy  output  1  state != IDLE

## Operation
- N = 4/NCOLS column groups. Group g covers columns g*NCOLS .. g*NCOLS+NCOLS-1. Column 0 (bits [31:0]) is processed first.
- Forward, per column a0..a3 → b0..b3: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
- Inverse: b0=Ea0^Ba1^Da2^9a3, b1=9a0^Ea1^Ba2^Da3, b2=Da0^9a1^Ea2^Ba3, b3=Ba0^Da1^9a2^Ea3.
- All products are in GF(2^8) with xtime reduction polynomial 0x11B.
- The same group is transformed in every share in the same cycle. Shares never mix.
- Registers: state[128*D], mode, group counter cnt (width clog2(N), min 1), FSM.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid: state<=in_data, mode<=in_inverse, cnt<=0, go to RUN.
  - RUN: in_ready=0. Each cycle, group cnt in state is replaced by its transform. If cnt==N-1, go to DONE; else cnt<=cnt+1.
  - DONE: out_valid=1, out_data=state. in_ready=out_ready.
    - out_ready=0: hold everything.
    - out_ready=1, in_valid=0: go to IDLE.
    - out_ready=1, in_valid=1: load the new transaction exactly as from IDLE and go to RUN (back-to-back, no bubble).
- in_data and in_inverse are ignored whenever in_ready=0.
- out_data is not required to hold any value outside DONE.

## Timing
- Reset (asynchronous assert): FSM=IDLE, cnt=0, mode=0, state=0. Out of reset: out_valid=0, busy=0, in_ready=1.
- Reset asserted mid-RUN or mid-DONE aborts the transaction. The result is never presented.
- Latency: out_valid rises N cycles after the accepting edge (NCOLS=1: 4, NCOLS=2: 2, NCOLS=4: 1).
- Throughput: one transaction per N+1 cycles with out_ready held at 1; a further cycle per stalled DONE cycle.
- Critical path per cycle: one inverse-column network (xtime chain up to depth 3, plus XOR tree) and a 2:1 mode mux.

## Test plan
- FIPS-197 forward, D=1, NCOLS=1: column bytes a0..a3=db,13,53,45 (in_data[31:0]=32'h455313db), other columns c6c6c6c6 / 01010101 / f20a225c.
  - Required: out[31:0]=32'hbca14d8e, columns 1–2 unchanged, column 3 = bytes 9f,dc,58,9d.
  - Required: out_valid exactly 4 cycles after accept.
- Inverse round trip for NCOLS ∈ {1,2,4}: feed the forward result above with in_inverse=1 → original state returned; out_valid latency 4/2/1.
- Shares, D=3: random shares whose XOR equals the vector above → XOR of output shares equals the FIPS result. Each share individually equals its own MixColumns image.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE: out_data and out_valid stable; in_ready=0.
  - Then out_ready=1 with in_valid=1: next transaction accepted in the same cycle; second result follows N cycles later.
- Reset mid-operation: assert rst_n=0 at the second RUN cycle (NCOLS=1). Required: out_valid=0 and busy=0 immediately, in_ready=1 after release, a fresh transaction gives the correct result.
- Mode latching: toggle in_inverse every cycle during RUN → result follows the mode sampled at accept.
